// File: rtl/fpu_issue_ctrl.sv
// Issues one FPU operation at a time, waits LATENCY cycles, returns reg_lo/reg_hi.
// Latency: strobe 1 cycle after accept, rsp_valid LATENCY+2 cycles after accept; req_ready only in IDLE, rsp held until rsp_ready.
module fpu_issue_ctrl #(
    parameter int unsigned LATENCY = 10,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_lo,
    output logic [31:0]      rsp_hi,
    output logic [4:0]       rsp_op,
    output logic             fpu_instr_received,
    output logic [4:0]       fpu_op_mask,
    output logic [31:0]      fpu_input_1,
    output logic [31:0]      fpu_input_2,
    input  logic [31:0]      fpu_reg_lo,
    input  logic [31:0]      fpu_reg_hi,
    output logic             busy,
    output logic [CNT_W-1:0] issue_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [7:0] WAIT_LOAD = 8'(LATENCY - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic       accept;
    logic       wait_done;

    assign accept    = (state == S_IDLE) && req_valid;
    assign wait_done = (state == S_WAIT) && (wait_cnt == 8'd0);

    // Handshake outputs are pure state decodes, so no combinational input-to-output paths.
    assign req_ready          = (state == S_IDLE);
    assign fpu_instr_received = (state == S_ISSUE);
    assign rsp_valid          = (state == S_RESP);
    assign busy               = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req_valid) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (wait_cnt == 8'd0) state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FPU-side operands only move on accept, so they stay put through WAIT and RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpu_op_mask <= 5'd0;
            fpu_input_1 <= 32'd0;
            fpu_input_2 <= 32'd0;
        end else if (accept) begin
            fpu_op_mask <= req_op;
            fpu_input_1 <= req_a;
            fpu_input_2 <= req_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= 8'd0;
            issue_count <= '0;
        end else if (state == S_ISSUE) begin
            wait_cnt    <= WAIT_LOAD;
            issue_count <= issue_count + CNT_W'(1);
        end else if ((state == S_WAIT) && (wait_cnt != 8'd0)) begin
            wait_cnt <= wait_cnt - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_lo <= 32'd0;
            rsp_hi <= 32'd0;
            rsp_op <= 5'd0;
        end else if (wait_done) begin
            rsp_lo <= fpu_reg_lo;
            rsp_hi <= fpu_reg_hi;
            rsp_op <= fpu_op_mask;
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: LATENCY=10 instance with a 10-cycle stub FPU, plus a
// LATENCY=1 / CNT_W=4 instance whose stub drives its result for exactly one cycle.
module tb_fpu_issue_ctrl;

    localparam logic [4:0] FMUL = 5'b00001;
    localparam logic [4:0] FMAX = 5'b00010;
    localparam logic [4:0] FMIN = 5'b00100;
    localparam logic [4:0] FADD = 5'b01000;
    localparam logic [4:0] FDIV = 5'b10000;
    localparam logic [31:0] JUNK = 32'hdeadbeef;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] lo;
        logic [31:0] hi;
    } exp_t;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // instance 1: LATENCY=10, CNT_W=16
    logic        req_valid, req_ready, rsp_valid, rsp_ready, strobe, busy;
    logic [4:0]  req_op, rsp_op, op_mask;
    logic [31:0] req_a, req_b, rsp_lo, rsp_hi, in1, in2, reg_lo, reg_hi;
    logic [15:0] issue_count;

    // instance 2: LATENCY=1, CNT_W=4
    logic        req2_valid, req2_ready, rsp2_valid, rsp2_ready, strobe2, busy2;
    logic [4:0]  req2_op, rsp2_op, op2_mask;
    logic [31:0] req2_a, req2_b, rsp2_lo, rsp2_hi, in2_1, in2_2, reg2_lo, reg2_hi;
    logic [3:0]  issue_count2;

    fpu_issue_ctrl #(.LATENCY(10), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_lo(rsp_lo),
        .rsp_hi(rsp_hi), .rsp_op(rsp_op),
        .fpu_instr_received(strobe), .fpu_op_mask(op_mask),
        .fpu_input_1(in1), .fpu_input_2(in2),
        .fpu_reg_lo(reg_lo), .fpu_reg_hi(reg_hi),
        .busy(busy), .issue_count(issue_count)
    );

    fpu_issue_ctrl #(.LATENCY(1), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req2_valid), .req_ready(req2_ready), .req_op(req2_op),
        .req_a(req2_a), .req_b(req2_b),
        .rsp_valid(rsp2_valid), .rsp_ready(rsp2_ready), .rsp_lo(rsp2_lo),
        .rsp_hi(rsp2_hi), .rsp_op(rsp2_op),
        .fpu_instr_received(strobe2), .fpu_op_mask(op2_mask),
        .fpu_input_1(in2_1), .fpu_input_2(in2_2),
        .fpu_reg_lo(reg2_lo), .fpu_reg_hi(reg2_hi),
        .busy(busy2), .issue_count(issue_count2)
    );

    exp_t exp_q[$];
    exp_t exp2_q[$];
    res_t stub_q[$];
    res_t stub2_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stub FPU 1: junk right after the strobe, the answer from 10 cycles after it onward.
    res_t pend;
    int   scnt = 0;
    always @(posedge clk) begin
        if (strobe) begin
            if (stub_q.size() == 0) begin
                errors++;
                $display("FAIL stub1_unexpected_strobe at cycle %0d", cyc);
            end else begin
                pend = stub_q.pop_front();
            end
            scnt = 9;
            reg_lo <= JUNK;
            reg_hi <= JUNK;
        end else if (scnt > 0) begin
            scnt = scnt - 1;
            if (scnt == 0) begin
                reg_lo <= pend.lo;
                reg_hi <= pend.hi;
            end
        end
    end

    // Stub FPU 2: answer valid only in the single cycle after the strobe.
    res_t pend2;
    always @(posedge clk) begin
        if (strobe2) begin
            if (stub2_q.size() == 0) begin
                errors++;
                $display("FAIL stub2_unexpected_strobe at cycle %0d", cyc);
                reg2_lo <= JUNK;
                reg2_hi <= JUNK;
            end else begin
                pend2 = stub2_q.pop_front();
                reg2_lo <= pend2.lo;
                reg2_hi <= pend2.hi;
            end
        end else begin
            reg2_lo <= JUNK;
            reg2_hi <= JUNK;
        end
    end

    // Scoreboards: compare on every completed response handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb1_unexpected_rsp lo=%h", rsp_lo);
            end else begin
                e = exp_q.pop_front();
                chk("sb1_op", {27'd0, rsp_op}, {27'd0, e.op});
                chk("sb1_lo", rsp_lo, e.lo);
                chk("sb1_hi", rsp_hi, e.hi);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rsp2_valid && rsp2_ready) begin
            if (exp2_q.size() == 0) begin
                errors++;
                $display("FAIL sb2_unexpected_rsp lo=%h", rsp2_lo);
            end else begin
                e = exp2_q.pop_front();
                chk("sb2_op", {27'd0, rsp2_op}, {27'd0, e.op});
                chk("sb2_lo", rsp2_lo, e.lo);
                chk("sb2_hi", rsp2_hi, e.hi);
            end
        end
    end

    // FPU-side operands must hold from the strobe until the controller is idle again.
    logic [31:0] cap1, cap2;
    logic [4:0]  capop;
    logic        have_cap = 1'b0;
    always @(negedge clk) begin
        if (strobe) begin
            cap1 = in1;
            cap2 = in2;
            capop = op_mask;
            have_cap = 1'b1;
        end else if (busy && have_cap) begin
            chk("stable_in1", in1, cap1);
            chk("stable_in2", in2, cap2);
            chk("stable_op", {27'd0, op_mask}, {27'd0, capop});
        end
    end

    task automatic issue1(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lo, input logic [31:0] hi, output int base);
        int n;
        stub_q.push_back('{lo: lo, hi: hi});
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        n = 0;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
        chk("accept_ready", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        req_op = FADD;
        req_a = 32'h12345678;
        req_b = 32'h9abcdef0;
        base = cyc;
        chk("strobe_cycle1", {31'd0, strobe}, 32'd1);
        chk("issue_in1", in1, a);
        chk("issue_in2", in2, b);
        chk("issue_op", {27'd0, op_mask}, {27'd0, op});
    endtask

    task automatic run1(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lo, input logic [31:0] hi, output int base);
        int k;
        exp_q.push_back('{op: op, lo: lo, hi: hi});
        issue1(op, a, b, lo, hi, base);
        k = 1;
        while (!rsp_valid && k < 300) begin
            tick();
            k++;
            if (strobe) chk("single_strobe", {31'd0, strobe}, 32'd0);
        end
        chk("rsp_valid_cycle", 32'(k), 32'd12);
    endtask

    task automatic run2(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lo, input logic [31:0] hi);
        int n;
        int k;
        exp2_q.push_back('{op: op, lo: lo, hi: hi});
        stub2_q.push_back('{lo: lo, hi: hi});
        req2_valid = 1'b1;
        req2_op = op;
        req2_a = a;
        req2_b = b;
        n = 0;
        while (!req2_ready && n < 200) begin
            tick();
            n++;
        end
        chk("accept2_ready", {31'd0, req2_ready}, 32'd1);
        tick();
        req2_valid = 1'b0;
        chk("strobe2_cycle1", {31'd0, strobe2}, 32'd1);
        k = 1;
        while (!rsp2_valid && k < 100) begin
            tick();
            k++;
        end
        chk("rsp2_valid_cycle", 32'(k), 32'd3);
    endtask

    initial begin
        int b0, b1;
        req_valid = 1'b0; req_op = 5'd0; req_a = 32'd0; req_b = 32'd0; rsp_ready = 1'b1;
        req2_valid = 1'b0; req2_op = 5'd0; req2_a = 32'd0; req2_b = 32'd0; rsp2_ready = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        tick();
        tick();
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_strobe", {31'd0, strobe}, 32'd0);
        chk("rst_in1", in1, 32'd0);
        chk("rst_count", {16'd0, issue_count}, 32'd0);
        chk("rst_rsp_lo", rsp_lo, 32'd0);
        rst_n = 1'b1;
        tick();

        // single FMUL: -0.5 * 500.25 = -250.125
        run1(FMUL, 32'hbf000000, 32'h43fa2000, 32'hc37a2000, 32'h00000001, b0);
        tick();
        chk("fmul_count", {16'd0, issue_count}, 32'd1);
        chk("fmul_ready_back", {31'd0, req_ready}, 32'd1);

        // backpressure with a competing request pending
        rsp_ready = 1'b0;
        run1(FMAX, 32'h43fa2000, 32'hbf000000, 32'h43fa2000, 32'h00000002, b0);
        req_valid = 1'b1;
        req_op = FADD;
        req_a = 32'h40400000;
        req_b = 32'h40400000;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_lo", rsp_lo, 32'h43fa2000);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
            chk("bp_no_strobe", {31'd0, strobe}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        chk("bp_count", {16'd0, issue_count}, 32'd2);

        // back-to-back FMIN then FMUL 1.0*1.0
        run1(FMIN, 32'h43fa2000, 32'hbf000000, 32'hbf000000, 32'h00000003, b0);
        run1(FMUL, 32'h3f800000, 32'h3f800000, 32'h3f800000, 32'h00000004, b1);
        chk("b2b_strobe_gap", 32'(b1 - b0), 32'd13);
        tick();
        chk("b2b_count", {16'd0, issue_count}, 32'd4);

        // reset in cycle 5 (mid-WAIT) aborts the op
        issue1(FDIV, 32'h40400000, 32'h40000000, 32'h3fc00000, 32'h00000005, b0);
        repeat (4) tick();
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_in1", in1, 32'd0);
        chk("abort_in2", in2, 32'd0);
        chk("abort_op", {27'd0, op_mask}, 32'd0);
        chk("abort_count", {16'd0, issue_count}, 32'd0);
        chk("abort_rsp_op", {27'd0, rsp_op}, 32'd0);
        repeat (3) begin
            tick();
            chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
        run1(FADD, 32'h3f800000, 32'h3f800000, 32'h40000000, 32'h00000006, b0);
        tick();
        chk("post_rst_count", {16'd0, issue_count}, 32'd1);

        // LATENCY=1 and 4-bit counter wrap over 17 ops
        for (int i = 0; i < 17; i++) begin
            run2(FADD, 32'h3f800000 + 32'(i), 32'h40000000, 32'h40400000 + 32'(i), 32'h00000100 + 32'(i));
            if (i == 15) chk("wrap_to_zero", {28'd0, issue_count2}, 32'd0);
        end
        tick();
        chk("wrap_count", {28'd0, issue_count2}, 32'd1);

        repeat (3) tick();
        chk("sb1_drained", 32'(exp_q.size()), 32'd0);
        chk("sb2_drained", 32'(exp2_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
